// File: rtl/osc_sample_gen_if.sv
// Sample output channel of osc_sample_gen: one-entry valid/ready handshake.
// master = producer (osc_sample_gen), slave = consumer (AC97 output path).
interface osc_sample_gen_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/osc_sample_gen.sv
// osc_sample_gen: phase accumulator stepped once per osc_clk rising edge,
// waveform shaping (saw/square/triangle/silence) and a one-entry valid/ready
// output buffer. Everything runs on sys_clk; osc_clk is a synchronous level.
// Optional drop counter output enabled by defining OSC_SAMPLE_DROP_CNT_EN.
module osc_sample_gen #(
  parameter int PHASE_W  = 16,
  parameter int SAMPLE_W = 16
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               osc_enable,
  input  logic               osc_clk,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [1:0]         wave_sel,
  osc_sample_gen_if.master   smp,
`ifdef OSC_SAMPLE_DROP_CNT_EN
  output logic [7:0]         drop_count,
`endif
  output logic               overrun
);

  localparam logic [1:0] WAVE_SAW = 2'd0;
  localparam logic [1:0] WAVE_SQR = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;

  logic                osc_q;
  logic                edge_q;
  logic [PHASE_W-1:0]  phase;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q;
  logic                ovr_q;
  logic                osc_edge;
  logic                xfer;
  logic [SAMPLE_W-1:0] p;
  logic [SAMPLE_W-2:0] tri_t;
  logic [SAMPLE_W-1:0] wave;

  assign osc_edge         = osc_clk & ~osc_q & osc_enable;
  assign xfer             = valid_q & smp.sample_ready;
  assign smp.sample       = sample_q;
  assign smp.sample_valid = valid_q;
  assign overrun          = ovr_q;

  // Edge detect and phase step; edge_q marks a fresh phase for the compute stage.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      osc_q  <= 1'b0;
      edge_q <= 1'b0;
      phase  <= '0;
    end else begin
      osc_q  <= osc_clk;
      edge_q <= osc_edge;
      if (osc_edge) phase <= phase + phase_inc;
    end
  end

  // Waveform shaping from the top SAMPLE_W bits of the updated phase.
  always_comb begin
    p     = phase[PHASE_W-1 -: SAMPLE_W];
    tri_t = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
    wave  = '0;
    case (wave_sel)
      WAVE_SAW: wave = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
      WAVE_SQR: wave = {p[SAMPLE_W-1], {(SAMPLE_W-1){~p[SAMPLE_W-1]}}};
      WAVE_TRI: wave = {~tri_t[SAMPLE_W-2], tri_t[SAMPLE_W-3:0], 1'b0};
      default:  wave = '0;
    endcase
  end

  // One-entry buffer: load when empty or draining this cycle, otherwise drop.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else if (edge_q) begin
      if (!valid_q || xfer) begin
        sample_q <= wave;
        valid_q  <= 1'b1;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

`ifdef OSC_SAMPLE_DROP_CNT_EN
  // Saturating count of samples dropped because the buffer was full.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      drop_count <= 8'd0;
    end else if (edge_q && valid_q && !xfer && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_osc_sample_gen.sv
// Bench for osc_sample_gen: directed test-plan scenarios plus a randomized run,
// all checked against a cycle-level reference model that derives samples
// arithmetically from the phase.
module tb_osc_sample_gen;
  logic        sys_clk = 1'b0;
  logic        reset   = 1'b0;
  logic        osc_enable = 1'b1;
  logic        osc_clk = 1'b0;
  logic [15:0] phase_inc = 16'h0;
  logic [1:0]  wave_sel = 2'd0;
  logic        overrun;
`ifdef OSC_SAMPLE_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  osc_sample_gen_if #(.SAMPLE_W(16)) bus ();

  osc_sample_gen #(.PHASE_W(16), .SAMPLE_W(16)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .osc_enable (osc_enable),
    .osc_clk    (osc_clk),
    .phase_inc  (phase_inc),
    .wave_sel   (wave_sel),
    .smp        (bus.master),
`ifdef OSC_SAMPLE_DROP_CNT_EN
    .drop_count (drop_count),
`endif
    .overrun    (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference waveform: signed value computed directly from the phase.
  function automatic logic [15:0] ref_wave(input logic [15:0] ph, input logic [1:0] sel);
    int pv;
    int v;
    pv = int'(ph);
    case (sel)
      2'd0:    v = pv - 32768;
      2'd1:    v = (pv < 32768) ? 32767 : -32768;
      2'd2:    v = (pv < 32768) ? (2 * pv - 32768) : (2 * (65535 - pv) - 32768);
      default: v = 0;
    endcase
    return v[15:0];
  endfunction

  // Reference model: step pending from the previous edge, then buffer rules.
  logic [15:0] m_phase, m_sample;
  logic        m_prev, m_pend, m_valid, m_ovr;
  int          m_drop;
  always @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 16'h0; m_sample <= 16'h0; m_prev <= 1'b0; m_pend <= 1'b0;
      m_valid <= 1'b0;  m_ovr <= 1'b0;     m_drop <= 0;
    end else begin
      if (m_pend) begin
        if (!m_valid || bus.sample_ready) begin
          m_sample <= ref_wave(m_phase, wave_sel);
          m_valid  <= 1'b1;
        end else begin
          m_ovr  <= 1'b1;
          m_drop <= (m_drop >= 255) ? 255 : m_drop + 1;
        end
      end else if (m_valid && bus.sample_ready) begin
        m_valid <= 1'b0;
      end
      m_pend <= osc_clk && !m_prev && osc_enable;
      if (osc_clk && !m_prev && osc_enable) m_phase <= m_phase + phase_inc;
      m_prev <= osc_clk;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    chk("m_valid", 32'(bus.sample_valid), 32'(m_valid));
    if (m_valid) chk("m_sample", 32'(bus.sample), 32'(m_sample));
    chk("m_overrun", 32'(overrun), 32'(m_ovr));
`ifdef OSC_SAMPLE_DROP_CNT_EN
    chk("m_drop", 32'(drop_count), 32'(m_drop));
`endif
  end

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One-cycle osc_clk pulse; the resulting sample is loaded by its end.
  task automatic pulse();
    osc_clk = 1'b1; step(1);
    osc_clk = 1'b0; step(1);
  endtask

  task automatic do_reset();
    reset = 1'b0; step(2);
    reset = 1'b1; step(1);
  endtask

  initial begin
    logic [15:0] exp_s;
    bus.sample_ready = 1'b1;
    step(3);
    chk("rst_sample", 32'(bus.sample), 32'h0);
    chk("rst_valid", 32'(bus.sample_valid), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    reset = 1'b1; step(1);

    // Saw: three steps of 0x1000, valid on the second edge after osc_clk seen high.
    phase_inc = 16'h1000; wave_sel = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      exp_s = 16'h8000 + 16'(i) * 16'h1000;
      osc_clk = 1'b1; step(1);
      chk("saw_lat0", 32'(bus.sample_valid), 32'h0);
      osc_clk = 1'b0; step(1);
      chk("saw_valid", 32'(bus.sample_valid), 32'h1);
      chk("saw_sample", 32'(bus.sample), 32'(exp_s));
      step(2);
    end

    // Square with wrap; a long osc_clk high is one step only.
    do_reset();
    phase_inc = 16'h8000; wave_sel = 2'd1;
    osc_clk = 1'b1; step(2);
    chk("sq_first", 32'(bus.sample), 32'h8000);
    step(8);
    chk("sq_hold_valid", 32'(bus.sample_valid), 32'h0);
    chk("sq_hold_sample", 32'(bus.sample), 32'h8000);
    osc_clk = 1'b0; step(1);
    pulse();
    chk("sq_wrap", 32'(bus.sample), 32'h7FFF);
    step(2);

    // Same-cycle transfer plus load, then backpressure drop.
    do_reset();
    phase_inc = 16'h1000; wave_sel = 2'd0; bus.sample_ready = 1'b0;
    pulse();
    chk("bp_first", 32'(bus.sample), 32'h9000);
    osc_clk = 1'b1; step(1);
    bus.sample_ready = 1'b1; osc_clk = 1'b0; step(1);
    bus.sample_ready = 1'b0;
    chk("same_valid", 32'(bus.sample_valid), 32'h1);
    chk("same_sample", 32'(bus.sample), 32'hA000);
    chk("same_ovr", 32'(overrun), 32'h0);
    pulse();
    step(1);
    chk("bp_keep", 32'(bus.sample), 32'hA000);
    chk("bp_ovr", 32'(overrun), 32'h1);
`ifdef OSC_SAMPLE_DROP_CNT_EN
    chk("bp_drop", 32'(drop_count), 32'h1);
`endif
    bus.sample_ready = 1'b1; step(1);
    chk("bp_drain", 32'(bus.sample_valid), 32'h0);

    // Enable low: edges ignored, phase held; resumes from held phase.
    osc_enable = 1'b0;
    repeat (4) pulse();
    chk("en_idle", 32'(bus.sample_valid), 32'h0);
    osc_enable = 1'b1;
    pulse();
    chk("en_resume", 32'(bus.sample), 32'hC000);
    chk("en_ovr", 32'(overrun), 32'h1);
    step(2);

    // Reset mid-step: in-flight sample discarded, outputs clear immediately.
    osc_clk = 1'b1; step(1);
    #2 reset = 1'b0;
    #1;
    chk("arst_sample", 32'(bus.sample), 32'h0);
    chk("arst_valid", 32'(bus.sample_valid), 32'h0);
    chk("arst_ovr", 32'(overrun), 32'h0);
    osc_clk = 1'b0; step(1);
    reset = 1'b1; step(3);
    chk("arst_none", 32'(bus.sample_valid), 32'h0);

    // Randomized run, checked by the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) osc_clk = ~osc_clk;
      osc_enable = ($urandom_range(0, 7) != 0);
      bus.sample_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) phase_inc = 16'($urandom);
      if ($urandom_range(0, 15) == 0) wave_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0) phase_inc = 16'h0;
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/osc_sample_gen.md
Name: osc_sample_gen

Overview:
- Consumer end of the oscillator clock: takes the osc_clk rate strobe produced by the oscillator clock block and advances a phase accumulator once per osc_clk rising edge.
- Converts the phase into a signed waveform sample.
- Offers each sample to the AC97 output path through a one-entry valid/ready buffer.
- Runs entirely in the sys_clk domain; osc_clk is a sys_clk-synchronous level.

Parameters:
- PHASE_W, 16, phase accumulator width in bits.
- SAMPLE_W, 16, output sample width in bits; must satisfy SAMPLE_W <= PHASE_W.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- osc_enable  in  1  run enable. Low: edges ignored, phase frozen.
- osc_clk  in  1  oscillator rate strobe; one step per rising edge.
- phase_inc  in  PHASE_W  per-step phase increment, unsigned.
- wave_sel  in  2  waveform: 0 saw, 1 square, 2 triangle, 3 silence.
- sample  out  SAMPLE_W  signed two's-complement sample.
- sample_valid  out  1  sample holds an unconsumed value.
- sample_ready  in  1  downstream accepts when high with sample_valid.
- overrun  out  1  sticky flag: a computed sample was dropped.

Behaviour:
- Reset (reset low, async): osc_q, edge_q, phase, sample, sample_valid, overrun and drop_count all go to 0 immediately. Any in-flight step is discarded.
- Edge detect:
  - osc_q <= osc_clk.
  - edge = osc_clk & ~osc_q & osc_enable.
  - osc_clk held high for many cycles gives exactly one edge.
- Pipeline, with the edge seen at cycle N:
  - N+1: phase <= phase + phase_inc, mod 2^PHASE_W with natural wrap; edge_q = 1.
  - N+2: computed sample offered to the buffer.
  - Latency from osc_clk sampled high to sample_valid = 2 cycles.
- Compute stage:
  - p = phase[PHASE_W-1 -: SAMPLE_W], using the updated phase; wave_sel sampled in the same cycle.
  - Saw: p with MSB inverted.
  - Square: MSB 0 gives 0x7FFF..; MSB 1 gives 0x800...
  - Triangle: t = MSB ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0]; result is {t,1'b0} with MSB inverted.
  - Silence: 0.
- Buffer / handshake (one entry):
  - Transfer occurs when sample_valid & sample_ready at a clock edge.
  - Once valid, sample and sample_valid stay stable until transfer.
  - Transfer with no new sample: sample_valid <= 0; sample holds its last value.
  - New sample with buffer empty: load it; sample_valid <= 1.
  - New sample in the same cycle as a transfer: load it; sample_valid stays 1.
  - New sample with buffer full and no transfer: drop the new sample, set overrun; the buffer keeps the older sample.
  - overrun clears only on reset.
- osc_enable:
  - Low: edges ignored, phase held.
  - An already-computed sample (edge_q set) still completes.
  - A buffered sample stays valid until consumed.
  - Re-enable resumes from the held phase; phase does not reset.
- phase_inc: may change at any time; takes effect on the next edge. phase_inc = 0 produces repeated identical samples.

Optional Feature:
- Macro: OSC_SAMPLE_DROP_CNT_EN.
- Defined:
  - Extra output port drop_count [7:0].
  - Increments by 1 on each dropped sample, saturating at 255.
  - Reset value 0.
- Undefined: port and counter absent; only overrun reports drops.

Test Plan (PHASE_W = SAMPLE_W = 16):
- Reset: assert reset low mid-run -> sample=0, sample_valid=0, overrun=0 asynchronously, with no sample emerging after release.
- Saw: phase_inc=0x1000, wave_sel=0, sample_ready=1, three osc_clk pulses -> samples 0x9000, 0xA000, 0xB000, each valid exactly 2 cycles after osc_clk is sampled high.
- Square wrap: phase_inc=0x8000, wave_sel=1 -> phase 0x8000 then 0x0000, giving samples 0x8000 then 0x7FFF. osc_clk held high for 10 cycles gives a single step.
- Backpressure: sample_ready=0, two edges -> first sample held, overrun=1, drop_count=1; then sample_ready=1 -> one transfer and sample_valid falls.
- Same-cycle transfer plus load: sample_ready pulsed in the cycle a new sample arrives -> sample_valid stays high, new value presented, overrun unchanged.
- Enable: osc_enable=0 with 4 edges -> phase unchanged, no new samples; re-enable and 1 edge -> step continues from the held phase (0x1000 increment).
